// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes and extends the immediate of a
// 32-bit instruction to XLEN bits behind a registered valid/ready stage with skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [7:0]       err_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } beat_t;

    // Formats are assembled at 64 bits and truncated, so XLEN=32 and 64 share one table.
    function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] ins, input logic [2:0] src);
        logic [63:0] wide;
        case (src)
            3'b000:  wide = {{52{ins[31]}}, ins[31:20]};
            3'b001:  wide = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'b101:  wide = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'b010:  wide = {{32{ins[31]}}, ins[31:12], 12'h000};
            3'b110:  wide = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'b011:  wide = {59'h0, ins[19:15]};
            3'b100:  wide = (XLEN == 64) ? {58'h0, ins[25:20]} : {59'h0, ins[24:20]};
            default: wide = 64'h0;
        endcase
        return wide[XLEN-1:0];
    endfunction

    function automatic logic is_illegal(input logic [2:0] src);
        return (src == 3'b111);
    endfunction

    beat_t      o_beat_r, o_beat_s;
    beat_t      k_beat_r, k_beat_s;
    beat_t      new_beat_s;
    logic       o_valid_r, o_valid_s;
    logic       k_valid_r, k_valid_s;
    logic [7:0] err_cnt_r, err_cnt_s;
    logic       consume_s;
    logic       accept_s;

    assign consume_s = o_valid_r && out_ready;
    assign accept_s  = in_valid && !k_valid_r;

    // Decode the incoming beat.
    always_comb begin
        new_beat_s.imm = ext_imm(instr, imm_src);
        new_beat_s.tag = in_tag;
        new_beat_s.ill = is_illegal(imm_src);
    end

    // Next-state for output and skid slots plus the saturating error counter.
    always_comb begin
        o_valid_s = o_valid_r;
        o_beat_s  = o_beat_r;
        k_valid_s = k_valid_r;
        k_beat_s  = k_beat_r;
        err_cnt_s = err_cnt_r;

        // Counting happens on delivery, so a beat consumed during flush still counts.
        if (consume_s && o_beat_r.ill && (err_cnt_r != 8'hFF)) begin
            err_cnt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_s = err_cnt_r;
        end

        if (flush) begin
            o_valid_s = 1'b0;
            k_valid_s = 1'b0;
        end else if (consume_s || !o_valid_r) begin
            if (k_valid_r) begin
                o_beat_s  = k_beat_r;
                o_valid_s = 1'b1;
                k_valid_s = 1'b0;
            end else if (accept_s) begin
                o_beat_s  = new_beat_s;
                o_valid_s = 1'b1;
            end else begin
                o_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            k_beat_s  = new_beat_s;
            k_valid_s = 1'b1;
        end else begin
            k_valid_s = k_valid_r;
        end
    end

    // State registers; in-flight beats are dropped asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_r <= 1'b0;
            o_beat_r  <= '0;
            k_valid_r <= 1'b0;
            k_beat_r  <= '0;
            err_cnt_r <= 8'h00;
        end else begin
            o_valid_r <= o_valid_s;
            o_beat_r  <= o_beat_s;
            k_valid_r <= k_valid_s;
            k_beat_r  <= k_beat_s;
            err_cnt_r <= err_cnt_s;
        end
    end

    assign in_ready    = !k_valid_r;
    assign out_valid   = o_valid_r;
    assign imm_ext     = o_beat_r.imm;
    assign out_tag     = o_beat_r.tag;
    assign out_illegal = o_beat_r.ill;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_ext;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [7:0]  err_cnt;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] instr64;
    logic [2:0]  imm_src64;
    logic        out_valid64;
    logic [63:0] imm_ext64;
    logic [4:0]  out_tag64;
    logic        out_illegal64;
    logic [7:0]  err_cnt64;

    int vectors = 0;
    int miscompares = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .imm_src(imm_src),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .imm_ext(imm_ext), .out_tag(out_tag), .out_illegal(out_illegal), .err_cnt(err_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64), .instr(instr64), .imm_src(imm_src64),
        .in_tag(5'd9), .out_valid(out_valid64), .out_ready(1'b1),
        .imm_ext(imm_ext64), .out_tag(out_tag64), .out_illegal(out_illegal64), .err_cnt(err_cnt64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] f_instr [7];
    logic [2:0]  f_src   [7];
    logic [31:0] f_exp   [7];

    initial begin
        f_instr[0] = 32'hFFF00093; f_src[0] = 3'b000; f_exp[0] = 32'hFFFFFFFF;
        f_instr[1] = 32'h02000FA3; f_src[1] = 3'b001; f_exp[1] = 32'h0000003F;
        f_instr[2] = 32'hFE000EE3; f_src[2] = 3'b101; f_exp[2] = 32'hFFFFFFFC;
        f_instr[3] = 32'h800000B7; f_src[3] = 3'b010; f_exp[3] = 32'h80000000;
        f_instr[4] = 32'h0010006F; f_src[4] = 3'b110; f_exp[4] = 32'h00000800;
        f_instr[5] = 32'h000F8073; f_src[5] = 3'b011; f_exp[5] = 32'h0000001F;
        f_instr[6] = 32'h03F01013; f_src[6] = 3'b100; f_exp[6] = 32'h0000001F;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = 32'h0; imm_src = 3'b000;
        in_tag = 5'd0; out_ready = 1'b0;
        in_valid64 = 1'b0; instr64 = 32'h0; imm_src64 = 3'b000;

        // reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm_ext", imm_ext, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_err_cnt", err_cnt, 0);
        #10 rst_n = 1'b1;

        // formats, back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; instr = f_instr[i]; imm_src = f_src[i]; in_tag = 5'(i + 1);
            tick();
            chk("fmt_valid", out_valid, 1);
            chk("fmt_imm", imm_ext, f_exp[i]);
            chk("fmt_tag", out_tag, i + 1);
            chk("fmt_illegal", out_illegal, 0);
        end
        in_valid = 1'b0;
        tick();
        chk("fmt_drain_valid", out_valid, 0);
        chk("fmt_err_cnt", err_cnt, 0);

        // XLEN=64 instance
        in_valid64 = 1'b1; instr64 = 32'h800000B7; imm_src64 = 3'b010;
        tick();
        chk("x64_u_valid", out_valid64, 1);
        chk("x64_u_imm", imm_ext64, 64'hFFFFFFFF80000000);
        instr64 = 32'h03F01013; imm_src64 = 3'b100;
        tick();
        chk("x64_sh_imm", imm_ext64, 64'h000000000000003F);
        instr64 = 32'hFFF00093; imm_src64 = 3'b000;
        tick();
        chk("x64_i_imm", imm_ext64, 64'hFFFFFFFFFFFFFFFF);
        in_valid64 = 1'b0;

        // backpressure: tags 1,2,3 with out_ready low for 3 cycles
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'b000; in_tag = 5'd1;
        tick();
        chk("bp_o_tag1", out_tag, 1);
        chk("bp_ready_after1", in_ready, 1);
        in_tag = 5'd2; instr = 32'h800000B7; imm_src = 3'b010;
        tick();
        chk("bp_ready_after2", in_ready, 0);
        chk("bp_hold_tag", out_tag, 1);
        chk("bp_hold_imm", imm_ext, 32'hFFFFFFFF);
        in_tag = 5'd3; instr = 32'h000F8073; imm_src = 3'b011;
        tick();
        chk("bp_hold_tag2", out_tag, 1);
        chk("bp_hold_imm2", imm_ext, 32'hFFFFFFFF);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_ready_still0", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_seq_tag2", out_tag, 2);
        chk("bp_seq_imm2", imm_ext, 32'h80000000);
        chk("bp_ready_reopen", in_ready, 1);
        tick();
        chk("bp_seq_tag3", out_tag, 3);
        chk("bp_seq_imm3", imm_ext, 32'h0000001F);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // illegal select: 300 beats, counter saturates at 255
        in_valid = 1'b1; instr = 32'hFFFFFFFF; imm_src = 3'b111;
        for (int i = 0; i < 300; i++) begin
            in_tag = 5'(i);
            tick();
            chk("ill_valid", out_valid, 1);
            chk("ill_imm", imm_ext, 0);
            chk("ill_flag", out_illegal, 1);
            chk("ill_err_cnt", err_cnt, (i < 255) ? i : 255);
        end
        in_valid = 1'b0;
        tick();
        chk("ill_err_sat", err_cnt, 255);
        tick();
        chk("ill_err_nowrap", err_cnt, 255);

        // flush with O and K full
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'b000; in_tag = 5'd10;
        tick();
        in_tag = 5'd11;
        tick();
        chk("fl_k_full", in_ready, 0);
        flush = 1'b1; in_tag = 5'd12;
        tick();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_no_residue", out_valid, 0);
        chk("fl_err_cnt", err_cnt, 255);

        // flush while a beat is accepted into an empty slot
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 5'd13;
        tick();
        chk("fl2_o_loaded", out_tag, 13);
        flush = 1'b1; in_tag = 5'd14;
        tick();
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_in_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl2_beat_dropped", out_valid, 0);

        // asynchronous reset mid-burst
        in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'b000; in_tag = 5'd20;
        tick();
        in_tag = 5'd21;
        tick();
        chk("ar_pre_tag", out_tag, 21);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_imm_ext", imm_ext, 0);
        chk("ar_out_tag", out_tag, 0);
        chk("ar_out_illegal", out_illegal, 0);
        chk("ar_err_cnt", err_cnt, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        in_valid = 1'b1; in_tag = 5'd7; instr = 32'h0010006F; imm_src = 3'b110;
        #1;
        chk("ar_idle_before_edge", out_valid, 0);
        tick();
        chk("ar_first_valid", out_valid, 1);
        chk("ar_first_tag", out_tag, 7);
        chk("ar_first_imm", imm_ext, 32'h00000800);
        in_valid = 1'b0;
        tick();
        chk("ar_drain", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the pipelined CPU. It extracts and sign/zero-extends the immediate field of a 32-bit RISC-V instruction to XLEN bits. Compared with the single-cycle immediate generator it adds CSR-zimm and shift-amount formats, flags illegal selects, and carries a tag with each result. Results pass through a registered valid/ready output stage with a one-entry skid buffer, and the block supports synchronous flush.

## Interface
- XLEN, default 32: result width; legal values are 32 and 64.
- TAG_W, default 5: width of the sideband tag carried with each beat (PC index or register id).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- instr  input  32  full instruction word.
- imm_src  input  3  format select.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- imm_ext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  result came from an illegal imm_src.
- err_cnt  output  8  saturating count of delivered illegal beats.

## Operation
Formats are selected by imm_src. sext means sign-extend to XLEN; zext means zero-extend to XLEN.
- 000 I: sext(instr[31:20]).
- 001 S: sext({instr[31:25], instr[11:7]}).
- 101 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- 010 U: sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 copy instr[31].
- 110 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- 011 Z: zext(instr[19:15]), the CSR immediate.
- 100 SH: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
- 111: illegal. imm_ext = 0 and out_illegal = 1. Every other select gives out_illegal = 0.

Datapath and buffering:
- The extension logic is combinational on the input side.
- The result, tag and illegal flag are captured into the output register (O) or the skid register (K).

Accept and load rules:
- in_ready = !K_valid. It is driven from a register, with no combinational path from out_ready.
- A beat is accepted when in_valid && in_ready.
- An accepted beat loads into O if O is empty or is being consumed this cycle (out_valid && out_ready). Otherwise it loads into K.
- When O is consumed while K is valid, K moves to O and K empties.
- No beat is accepted in that cycle, because in_ready is 0 whenever K is valid.
- Beats leave in acceptance order. None is dropped or duplicated, except on flush.

Error counter:
- err_cnt increments when a beat with out_illegal = 1 is consumed (out_valid && out_ready).
- It saturates at 255 and is never cleared by flush.

## Timing
Reset values, asynchronous on rst_n low:
- out_valid = 0, K_valid = 0, so in_ready = 1.
- imm_ext = 0, out_tag = 0, out_illegal = 0, err_cnt = 0.

Latency and throughput:
- A beat accepted at edge N appears on out_valid/imm_ext after edge N, with 1-cycle latency.
- Sustained throughput is 1 beat per cycle while out_ready = 1.

Backpressure:
- While out_valid && !out_ready, imm_ext, out_tag and out_illegal hold stable.
- With out_ready held low, the first beat fills O and the second fills K. in_ready is 0 from the following cycle.

Flush:
- At the next edge, O_valid and K_valid clear, so out_valid = 0 and in_ready = 1.
- A beat accepted in the flush cycle is discarded.
- A beat consumed in the flush cycle counts as consumed, and it still updates err_cnt.

Reset mid-operation:
- All in-flight beats are lost and outputs return to their reset values immediately.

Simultaneous events:
- Consume O with K empty plus a new accept in the same cycle: the new beat lands in O and out_valid stays 1.

## Test plan
All scenarios use XLEN=32 unless stated.
- Formats with out_ready = 1:
  - instr 0xFFF00093 (I) -> 0xFFFFFFFF.
  - 0xFE000EE3 (B) -> 0xFFFFFFFC.
  - 0x0010006F (J) -> 0x00000800.
  - 0x800000B7 (U) -> 0x80000000.
  - 0x000F8073 (Z) -> 0x0000001F.
  - Each result appears 1 cycle after acceptance with its in_tag.
- XLEN=64:
  - 0x800000B7 (U) -> 0xFFFFFFFF80000000.
  - 0x03F01013 (SH) -> 0x000000000000003F.
- Backpressure: send tags 1, 2, 3 back-to-back with out_ready = 0 for 3 cycles.
  - in_ready = 0 after tag 2 is accepted.
  - Output holds tag 1, stable.
  - After out_ready = 1, the bench sees tags 1, 2, 3 in order, with no loss.
- Illegal select: send 300 beats with imm_src = 111.
  - Every result has imm_ext = 0 and out_illegal = 1.
  - err_cnt reads 255 and never wraps.
- Flush: fill O and K, then assert flush together with in_valid.
  - Next cycle: out_valid = 0 and in_ready = 1.
  - The flush-cycle beat never appears.
  - err_cnt is unchanged.
- Async reset: drop rst_n mid-burst.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, the first new beat appears after 1 cycle.
